// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: op encoding and FSM states.
package shift_pkg;

  // Shift operation selector, captured with the operand.
  typedef logic [1:0] op_t;

  localparam op_t OP_SLL = 2'b00;
  localparam op_t OP_SRL = 2'b01;
  localparam op_t OP_SRA = 2'b10;
  localparam op_t OP_ROR = 2'b11;

  // Control FSM: wait for operand, walk the stages, present result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage.sv
// One power-of-two shift stage: shifts data by 2^k using op, or passes it
// through when en is low. The stage index is a run-time input so a single
// instance serves every iteration of the unit.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         data,
  input  op_t                      op,
  input  logic [$clog2(WIDTH)-1:0] k,
  input  logic                     en,
  output logic [WIDTH-1:0]         q
);

  localparam int SHAMT_W = $clog2(WIDTH);

  // 2^k never exceeds WIDTH/2; one extra bit keeps WIDTH - 2^k representable.
  logic [SHAMT_W:0] amt;
  logic [SHAMT_W:0] wrap;

  // Select the shifted or held value for this stage.
  always_comb begin
    amt  = (SHAMT_W+1)'(1) << k;
    wrap = (SHAMT_W+1)'(WIDTH) - amt;
    q    = data;
    if (en) begin
      case (op)
        OP_SLL:  q = data << amt;
        OP_SRL:  q = data >> amt;
        // Working MSB is the operand sign at every stage, so >>> is exact.
        OP_SRA:  q = $signed(data) >>> amt;
        default: q = (data >> amt) | (data << wrap);
      endcase
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// Iterative shifter: applies one power-of-two stage per clock, from WIDTH/2
// down to 1, selected by the captured shift amount MSB first.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Producers hold valid and payload stable until that edge; the
// unit holds out_valid/out_data stable until out_ready is seen. in_ready is
// combinational from out_ready so a new operand can be taken on the same
// edge that consumes the previous result.
//
// WIDTH must be a power of two and at least 4.
module iter_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  op_t                      in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     busy,
  output state_t                   dbg_state
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t               state, state_nxt;
  logic                 accept;
  logic [SHAMT_W-1:0]   cnt;
  logic [SHAMT_W-1:0]   shamt_q;
  op_t                  op_q;
  logic [WIDTH-1:0]     work;
  logic [WIDTH-1:0]     stage_q;

  shift_stage #(.WIDTH(WIDTH)) u_stage (
    .data (work),
    .op   (op_q),
    .k    (cnt),
    .en   (shamt_q[cnt]),
    .q    (stage_q)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state, handshake outputs and operand-accept strobe.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept    = 1'b1;
            state_nxt = SHIFT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, stage counter and working register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      shamt_q <= '0;
      op_q    <= OP_SLL;
      work    <= '0;
    end else if (accept) begin
      cnt     <= SHAMT_W'(SHAMT_W - 1);
      shamt_q <= in_shamt;
      op_q    <= in_op;
      work    <= in_data;
    end else if (state == SHIFT) begin
      work <= stage_q;
      if (cnt != '0) cnt <= cnt - SHAMT_W'(1);
    end
  end

  assign out_data  = work;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: table-driven vectors through a scoreboard on the
// 32-bit instance, hand sequences for backpressure, back-to-back, reset
// mid-operation, and an 8-bit instance.
module tb_iter_shifter;
  import shift_pkg::*;

  localparam int W    = 32;
  localparam int SW   = 5;
  localparam int NVEC = 20;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT (WIDTH=32) ----------------
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [W-1:0]  in_data = '0, out_data;
  logic [SW-1:0] in_shamt = '0;
  logic [1:0]    in_op = 2'b00;
  state_t        dbg_state;

  iter_shifter #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- DUT (WIDTH=8) ----------------
  logic       v8 = 1'b0, rdy8, ov8, or8 = 1'b0, busy8;
  logic [7:0] d8 = '0, od8;
  logic [2:0] sh8 = '0;
  logic [1:0] op8 = 2'b00;
  state_t     dbg8;

  iter_shifter #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .in_shamt(sh8), .in_op(op8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8),
    .busy(busy8), .dbg_state(dbg8)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           hs_cyc[$];

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  data;
    logic [SW-1:0] shamt;
    logic [W-1:0]  exp;
  } vec_t;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: repeated single-bit steps.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] d, input int sh);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < sh; i++) begin
      case (op)
        2'b00:   r = {r[W-2:0], 1'b0};
        2'b01:   r = {1'b0, r[W-1:1]};
        2'b10:   r = {r[W-1], r[W-1:1]};
        default: r = {r[0], r[W-1:1]};
      endcase
    end
    return r;
  endfunction

  // ---------------- output monitor ----------------
  logic         prev_ov = 1'b0, prev_or = 1'b0;
  logic [W-1:0] prev_od = '0;
  int           valid_since = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_ov = 1'b0;
      prev_or = 1'b0;
    end else begin
      if (prev_ov && !prev_or) begin
        check("valid_held", {31'b0, out_valid}, 32'd1);
        if (out_valid) check("data_stable", out_data, prev_od);
      end
      if (out_valid && !(prev_ov && !prev_or)) valid_since = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", out_data, 32'hxxxx_xxxx);
        end else begin
          check("result", out_data, exp_q.pop_front());
          check("latency", valid_since, lat_q.pop_front());
          hs_cyc.push_back(cyc);
        end
      end
      prev_ov = out_valid;
      prev_or = out_ready;
      prev_od = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_in(input logic [1:0] op, input logic [W-1:0] data,
                          input logic [SW-1:0] sh, input logic [W-1:0] exp);
    bit done;
    done = 0;
    @(posedge clock); #1;
    in_valid = 1'b1; in_op = op; in_data = data; in_shamt = sh;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clock);
      if (in_ready) begin
        exp_q.push_back(exp);
        lat_q.push_back(cyc + 1 + SW);
        done = 1;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    // Scramble inputs after accept: captured values must be unaffected.
    in_op = ~op; in_data = $urandom; in_shamt = SW'($urandom_range(0, 31));
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      check("drain_timeout", 32'd0, 32'd1);
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // Directed vectors with hand-derived results, then random ones.
    vecs[0] = '{2'b10, 32'h8000_0000, 5'd16, 32'hFFFF_8000};
    vecs[1] = '{2'b01, 32'h8000_0000, 5'd16, 32'h0000_8000};
    vecs[2] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[3] = '{2'b11, 32'h0000_00F1, 5'd4,  32'h1000_000F};
    vecs[4] = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[5] = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[6] = '{2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[7] = '{2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[8] = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[9] = '{2'b11, 32'h0000_0001, 5'd31, 32'h0000_0002};
    for (int i = 10; i < NVEC; i++) begin
      vecs[i].op    = 2'($urandom_range(0, 3));
      vecs[i].data  = $urandom;
      vecs[i].shamt = SW'($urandom_range(0, 31));
      vecs[i].exp   = model(vecs[i].op, vecs[i].data, int'(vecs[i].shamt));
    end

    // Reset values.
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});

    // Table-driven single operations.
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive_in(vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].exp);
      wait_drain();
    end

    // Backpressure: hold result three cycles with a new operand waiting.
    out_ready = 1'b0;
    drive_in(2'b10, 32'h8000_0000, 5'd16, 32'hFFFF_8000);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (out_valid) seen = 1;
    end
    check("bp_valid_seen", {31'b0, seen}, 32'd1);
    fork
      drive_in(2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C);
      begin
        repeat (3) begin
          @(negedge clock);
          check("bp_in_ready", {31'b0, in_ready}, 32'd0);
          check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("bp_consumed", {31'b0, out_valid}, 32'd0);
        check("bp_busy_next", {31'b0, busy}, 32'd1);
      end
    join
    wait_drain();

    // Back-to-back with out_ready high: results six cycles apart, in order.
    hs_cyc.delete();
    drive_in(2'b11, 32'h1234_5678, 5'd8, 32'h7812_3456);
    drive_in(2'b01, 32'hF000_0000, 5'd28, 32'h0000_000F);
    wait_drain();
    if (hs_cyc.size() == 2) check("b2b_spacing", hs_cyc[1] - hs_cyc[0], 32'd6);
    else check("b2b_count", hs_cyc.size(), 32'd2);

    // Reset during the third shift stage.
    drive_in(2'b00, 32'h0000_00FF, 5'd31, 32'hxxxx_xxxx);
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    exp_q.delete();
    lat_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (out_valid) seen = 1;
    end
    check("no_stale_result", {31'b0, seen}, 32'd0);
    drive_in(2'b10, 32'hC000_0000, 5'd1, 32'hE000_0000);
    wait_drain();

    // WIDTH=8: SRA 0x90 by 3, result three edges after accept.
    @(posedge clock); #1;
    v8 = 1'b1; d8 = 8'h90; sh8 = 3'd3; op8 = 2'b10;
    @(negedge clock);
    check("w8_in_ready", {31'b0, rdy8}, 32'd1);
    @(posedge clock); #1;
    v8 = 1'b0; op8 = 2'b00;
    @(negedge clock);
    check("w8_valid_e0", {31'b0, ov8}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      check($sformatf("w8_valid_e%0d", i), {31'b0, ov8}, (i == 3) ? 32'd1 : 32'd0);
    end
    check("w8_data", {24'b0, od8}, 32'h0000_00F2);
    @(posedge clock); #1;
    or8 = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("w8_consumed", {31'b0, ov8}, 32'd0);
    or8 = 1'b0;

    if (exp_q.size() != 0) check("leftover_expected", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Multi-cycle, parametrised shift unit for the processor datapath. Performs logical left, logical right, arithmetic right and rotate-right shifts of a WIDTH-bit operand by a variable amount. It applies one power-of-two stage per clock (WIDTH/2, WIDTH/4, … 1), selected by the shift-amount bits from MSB to LSB. Operands are accepted and results delivered over valid/ready handshakes. It replaces the fixed-amount, fixed-width combinational shift blocks in the ALU's multi-cycle path.

## Interface
- WIDTH, 32, operand width; power of two, ≥ 4
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand offered
- in_ready  out  1  unit can accept an operand this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W  shift amount (unsigned)
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  WIDTH  result
- busy  out  1  operation accepted and not yet consumed

One clock; reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is high, capture in_data, in_shamt and in_op; load stage counter k=SHAMT_W-1; go to SHIFT.
- SHIFT:
  - Each edge: if shamt[k]=1, shift the working register by 2^k using the captured op; otherwise hold it.
  - Decrement k. After the k=0 edge, go to DONE.
- Stage rules:
  - SLL fills zeros at the LSB.
  - SRL fills zeros at the MSB.
  - SRA fills copies of the working register's bit WIDTH-1. This equals the operand sign at every stage.
  - ROR wraps the low 2^k bits into the MSBs.
- DONE:
  - out_valid=1; out_data is the working register, held stable while out_ready=0.
  - On out_valid&&out_ready: if in_valid, accept a new operand in the same edge and go to SHIFT. Otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from out_ready.
- busy = (state!=IDLE).
- shamt=0 still takes the full latency; the result equals the operand.
- in_op is captured at accept; later changes on in_op have no effect.

## Timing
- Reset values: state=IDLE, out_valid=0, out_data=0, busy=0, in_ready=1 (after reset_n deasserts), counter=0.
- Reset asserted mid-operation: clear immediately (asynchronous). The in-flight operand is discarded and no result is produced.
- Latency:
  - Accept edge E0; stage edges E1..E_SHAMT_W; out_valid high from edge E_SHAMT_W.
  - This is 5 cycles for WIDTH=32.
- Throughput with out_ready held high: one result every SHAMT_W+1 cycles (6 for WIDTH=32), because of the accept-on-consume rule.
- Handshakes:
  - in_valid is ignored in SHIFT. The producer holds in_valid/in_data until in_ready.
  - The unit never drops out_valid without a handshake.

## Structure
- Shared package `shift_pkg`:
  - op encoding localparams OP_SLL/OP_SRL/OP_SRA/OP_ROR;
  - the 2-bit op typedef;
  - FSM state encoding.
- Sub-module `shift_stage`:
  - combinational: data, op, stage index k, enable → data shifted by 2^k, or passthrough when enable=0;
  - parametrised by WIDTH;
  - one instance with a variable k mux. Instantiating SHAMT_W instances behind a selector is not permitted.
- Top module holds the FSM, counter, capture registers and working register.

## Test plan
- WIDTH=32, SRA, in_data=0x8000_0000, shamt=16 → out_data=0xFFFF_8000 with out_valid exactly 5 edges after accept; SRL with the same inputs → 0x0000_8000.
- SLL 0x0000_0001 by 31 → 0x8000_0000; ROR 0x0000_00F1 by 4 → 0x1000_000F; any op with shamt=0 on 0xDEAD_BEEF → 0xDEAD_BEEF.
- Backpressure: result ready with out_ready=0 for 3 cycles → out_data stable and out_valid held; in_ready=0 with in_valid high; the handshake completes on the first out_ready=1 edge.
- Back-to-back: in_valid and out_ready tied high, two operands → second accepted on the edge that consumes the first; results 6 cycles apart and in order.
- Reset mid-operation: assert reset_n=0 during SHIFT stage 3 → out_valid=0, busy=0, in_ready=1 immediately; no stale result appears after release.
- WIDTH=8, SRA 0x90 by 3 → 0xF2, with latency 3 edges.
